// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Opcode encodings, FSM states and flag indices for alu_seq_top.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int NB_FLAGS   = 4;
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ERR   = 3;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_btn_sync.sv
// ============================================================================
// Module  : alu_btn_sync
// Brief   : Multi-flop synchroniser plus rising-edge detector, one pulse per press.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_btn_sync #(
    parameter int NB_SYNC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [NB_SYNC-1:0] sync;
    logic               sync_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync      <= {sync[NB_SYNC-2:0], btn};
            sync_prev <= sync[NB_SYNC-1];
        end
    end

    assign pulse = sync[NB_SYNC-1] & ~sync_prev;

endmodule

`default_nettype wire

// File: rtl/alu_seq_top.sv
// ============================================================================
// Module  : alu_seq_top
// Brief   : Registered ALU loaded from a shared switch bus by three buttons.
//           Optional accumulator chaining enabled by defining ALU_ACCUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq_top
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int NB_SYNC = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_enable_1,
    input  logic                i_enable_2,
    input  logic                i_enable_3,
    output logic [NB_DATA-1:0]  o_data,
    output logic                o_carry,
    output logic                o_zero,
    output logic                o_overflow,
    output logic                o_err,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_led_data,
    output logic [3:0]          o_led_flags
);

    localparam int SHW = $clog2(NB_DATA);

    logic [2:0]          btn_async;
    logic [2:0]          load_pulse;
    logic [NB_DATA-1:0]  a_reg;
    logic [NB_DATA-1:0]  b_reg;
    logic [NB_OP-1:0]    op_reg;
    logic                a_v;
    logic                b_v;
    logic                op_v;
    logic                pending;
    logic                go;
    logic [0:0]          state;
    logic [NB_DATA-1:0]  result;
    logic [NB_FLAGS-1:0] flags;
    logic                valid;

    logic [NB_DATA:0]    sum_add;
    logic [NB_DATA:0]    sum_sub;
    logic [SHW-1:0]      shamt;
    logic [NB_DATA-1:0]  alu_res;
    logic [NB_FLAGS-1:0] alu_flags;

    assign btn_async = {i_enable_3, i_enable_2, i_enable_1};

    generate
        for (genvar g = 0; g < 3; g++) begin : g_btn
            alu_btn_sync #(
                .NB_SYNC (NB_SYNC)
            ) u_sync (
                .clk   (i_clk),
                .rst   (i_reset),
                .btn   (btn_async[g]),
                .pulse (load_pulse[g])
            );
        end
    endgenerate

    // pending remembers that a load happened, so a load landing during EXEC re-triggers later
    assign go = (state == ST_IDLE) && pending && a_v && b_v && op_v;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            a_v     <= 1'b0;
            b_v     <= 1'b0;
            op_v    <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (load_pulse[0]) begin
                a_reg <= i_data;
                a_v   <= 1'b1;
            end
`ifdef ALU_ACCUM_EN
            else if (state == ST_EXEC) begin
                a_reg <= alu_res;
            end
`endif
            if (load_pulse[1]) begin
                b_reg <= i_data;
                b_v   <= 1'b1;
            end
            if (load_pulse[2]) begin
                op_reg <= i_data[NB_OP-1:0];
                op_v   <= 1'b1;
            end
            pending <= (pending & ~go) | (|load_pulse);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= ST_IDLE;
            result <= '0;
            flags  <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result <= alu_res;
                    flags  <= alu_flags;
                    valid  <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sum_add = {1'b0, a_reg} + {1'b0, b_reg};
    assign sum_sub = {1'b0, a_reg} + {1'b0, ~b_reg} + {{NB_DATA{1'b0}}, 1'b1};
    assign shamt   = b_reg[SHW-1:0];

    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (op_reg)
            NB_OP'(OP_ADD): begin
                alu_res               = sum_add[NB_DATA-1:0];
                alu_flags[FLAG_CARRY] = sum_add[NB_DATA];
                alu_flags[FLAG_OVF]   = (a_reg[NB_DATA-1] == b_reg[NB_DATA-1]) &&
                                        (alu_res[NB_DATA-1] != a_reg[NB_DATA-1]);
            end
            NB_OP'(OP_SUB): begin
                alu_res               = sum_sub[NB_DATA-1:0];
                alu_flags[FLAG_CARRY] = sum_sub[NB_DATA];
                alu_flags[FLAG_OVF]   = (a_reg[NB_DATA-1] != b_reg[NB_DATA-1]) &&
                                        (alu_res[NB_DATA-1] != a_reg[NB_DATA-1]);
            end
            NB_OP'(OP_AND): alu_res = a_reg & b_reg;
            NB_OP'(OP_OR):  alu_res = a_reg | b_reg;
            NB_OP'(OP_XOR): alu_res = a_reg ^ b_reg;
            NB_OP'(OP_NOR): alu_res = ~(a_reg | b_reg);
            NB_OP'(OP_SRA): alu_res = $unsigned($signed(a_reg) >>> shamt);
            NB_OP'(OP_SRL): alu_res = a_reg >> shamt;
            default: begin
                alu_res             = '0;
                alu_flags[FLAG_ERR] = 1'b1;
            end
        endcase
        alu_flags[FLAG_ZERO] = (alu_res == '0);
    end

    assign o_data      = result;
    assign o_carry     = flags[FLAG_CARRY];
    assign o_zero      = flags[FLAG_ZERO];
    assign o_overflow  = flags[FLAG_OVF];
    assign o_err       = flags[FLAG_ERR];
    assign o_valid     = valid;
    assign o_led_data  = result;
    assign o_led_flags = {flags[FLAG_ERR], flags[FLAG_OVF], flags[FLAG_ZERO], flags[FLAG_CARRY]};

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_top.sv
// ============================================================================
// Module  : tb_alu_seq_top
// Brief   : Directed self-checking bench for alu_seq_top (honours ALU_ACCUM_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq_top;

    logic       clk;
    logic       i_reset;
    logic [7:0] i_data;
    logic       i_enable_1;
    logic       i_enable_2;
    logic       i_enable_3;
    logic [7:0] o_data;
    logic       o_carry;
    logic       o_zero;
    logic       o_overflow;
    logic       o_err;
    logic       o_valid;
    logic [7:0] o_led_data;
    logic [3:0] o_led_flags;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int long_v = 0;
    int vbase  = 0;
    logic prev_v = 1'b0;

    alu_seq_top #(
        .NB_DATA (8),
        .NB_OP   (6),
        .NB_SYNC (2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_data      (i_data),
        .i_enable_1  (i_enable_1),
        .i_enable_2  (i_enable_2),
        .i_enable_3  (i_enable_3),
        .o_data      (o_data),
        .o_carry     (o_carry),
        .o_zero      (o_zero),
        .o_overflow  (o_overflow),
        .o_err       (o_err),
        .o_valid     (o_valid),
        .o_led_data  (o_led_data),
        .o_led_flags (o_led_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid) vcnt <= vcnt + 1;
        if (o_valid && prev_v) long_v <= long_v + 1;
        prev_v <= o_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input int which, input logic v);
        case (which)
            1: i_enable_1 = v;
            2: i_enable_2 = v;
            default: i_enable_3 = v;
        endcase
    endtask

    task automatic press(input int which, input logic [7:0] d);
        @(negedge clk);
        i_data = d;
        set_en(which, 1'b1);
        repeat (4) @(negedge clk);
        set_en(which, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        i_reset    = 1'b1;
        i_data     = 8'h00;
        i_enable_1 = 1'b0;
        i_enable_2 = 1'b0;
        i_enable_3 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data",  {24'd0, o_data}, 32'h00);
        check("reset_flags", {28'd0, o_led_flags}, 32'h0);
        check("reset_valid", {31'd0, o_valid}, 32'h0);
        check("reset_led",   {24'd0, o_led_data}, 32'h00);
        i_reset = 1'b0;
        repeat (2) @(negedge clk);

        // ADD 0x7F + 0x01 with exact latency check
        press(1, 8'h7F);
        press(2, 8'h01);
        check("no_exec_before_op", vcnt, 0);
        @(negedge clk);
        i_data     = 8'h20;
        i_enable_3 = 1'b1;
        repeat (4) @(negedge clk);
        check("add_valid_early", {31'd0, o_valid}, 32'h0);
        @(negedge clk);
        check("add_valid_on", {31'd0, o_valid}, 32'h1);
        check("add_data",  {24'd0, o_data}, 32'h80);
        check("add_flags", {28'd0, o_led_flags}, 32'b0100);
        check("add_ovf",   {31'd0, o_overflow}, 32'h1);
        @(negedge clk);
        check("add_valid_off", {31'd0, o_valid}, 32'h0);
        i_enable_3 = 1'b0;
        repeat (6) @(negedge clk);
        check("add_led_data", {24'd0, o_led_data}, 32'h80);

        // SUB 5-5 then B reload to 6
        do_reset();
        press(1, 8'h05);
        press(2, 8'h05);
        vbase = vcnt;
        press(3, 8'h22);
        check("sub_data",  {24'd0, o_data}, 32'h00);
        check("sub_flags", {28'd0, o_led_flags}, 32'b0011);
        check("sub_vcnt",  vcnt - vbase, 1);
        press(2, 8'h06);
        check("sub2_data",  {24'd0, o_data}, 32'hFF);
        check("sub2_flags", {28'd0, o_led_flags}, 32'b0000);
        check("sub2_vcnt",  vcnt - vbase, 2);

        // shifts, illegal opcode, error clear
        do_reset();
        press(1, 8'h80);
        press(2, 8'h03);
        press(3, 8'h03);
        check("sra_data",  {24'd0, o_data}, 32'hF0);
        check("sra_flags", {28'd0, o_led_flags}, 32'b0000);
        press(3, 8'h02);
        check("srl_data", {24'd0, o_data}, 32'h10);
        press(3, 8'h3F);
        check("ill_data",  {24'd0, o_data}, 32'h00);
        check("ill_flags", {28'd0, o_led_flags}, 32'b1010);
        press(3, 8'h24);
        check("and_data",  {24'd0, o_data}, 32'h00);
        check("and_flags", {28'd0, o_led_flags}, 32'b0010);

        // long hold with glitches: exactly one B load
        do_reset();
        press(1, 8'h10);
        press(3, 8'h20);
        vbase = vcnt;
        @(negedge clk);
        i_data     = 8'h02;
        i_enable_2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 6) i_data = 8'h55;
            if (i == 10 || i == 14) begin
                #1 i_enable_2 = 1'b0;
                #2 i_enable_2 = 1'b1;
            end
        end
        @(negedge clk);
        i_enable_2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 i_enable_2 = 1'b1;
            #2 i_enable_2 = 1'b0;
        end
        repeat (10) @(negedge clk);
        check("hold_vcnt", vcnt - vbase, 1);
        check("hold_data", {24'd0, o_data}, 32'h12);

        // reset while EXEC is in flight
        vbase = vcnt;
        @(negedge clk);
        i_data     = 8'h22;
        i_enable_3 = 1'b1;
        repeat (4) @(negedge clk);
        i_reset = 1'b1;
        #1;
        check("rst_exec_data",  {24'd0, o_data}, 32'h00);
        check("rst_exec_led",   {24'd0, o_led_data}, 32'h00);
        check("rst_exec_flags", {28'd0, o_led_flags}, 32'h0);
        repeat (2) @(negedge clk);
        i_enable_3 = 1'b0;
        i_reset    = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_exec_novalid", vcnt - vbase, 0);
        press(2, 8'h01);
        check("rst_b_only_vcnt", vcnt - vbase, 0);
        check("rst_b_only_data", {24'd0, o_data}, 32'h00);

        // accumulator chain (or repeated result without the feature)
        do_reset();
        press(1, 8'h01);
        press(2, 8'h01);
        vbase = vcnt;
        press(3, 8'h20);
        check("acc_0", {24'd0, o_data}, 32'h02);
        for (int k = 1; k <= 3; k++) begin
            press(2, 8'h01);
`ifdef ALU_ACCUM_EN
            check($sformatf("acc_%0d", k), {24'd0, o_data}, 32'h02 + k);
`else
            check($sformatf("acc_%0d", k), {24'd0, o_data}, 32'h02);
`endif
        end
        check("acc_vcnt", vcnt - vbase, 4);
        check("valid_one_cycle", long_v, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq_top.md
Name: alu_seq_top

Overview:
Parametrised, registered successor of the board-level ALU top. Operands A and B and the opcode are loaded from the shared switch bus by three asynchronous push-button enables. Each enable is synchronised and edge-detected. A small FSM issues one registered execution per completed load set. Outputs are the result, flags and a one-cycle valid strobe, each also mirrored to LEDs.

Parameters:
NB_DATA, 8, operand/result width (>=4, power of 2)
NB_OP, 6, opcode width
NB_SYNC, 2, synchroniser flops per enable (>=2)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_data  in  NB_DATA  switch bus; opcode taken from i_data[NB_OP-1:0]
i_enable_1  in  1  async button: load A
i_enable_2  in  1  async button: load B
i_enable_3  in  1  async button: load opcode
o_data  out  NB_DATA  registered result
o_carry  out  1  carry / not-borrow
o_zero  out  1  result == 0
o_overflow  out  1  signed overflow (ADD/SUB only)
o_err  out  1  last executed opcode unsupported
o_valid  out  1  one-cycle strobe on result update
o_led_data  out  NB_DATA  mirror of o_data
o_led_flags  out  4  {o_err, o_overflow, o_zero, o_carry}

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is asynchronous and active-high. While asserted, all registers, sync flops, loaded flags, outputs and LEDs are 0; FSM goes to IDLE. Deassertion takes effect at the next edge.
- Enable path: NB_SYNC-flop synchroniser, then rising-edge detect (sync_last & ~sync_prev). Exactly one load per press, regardless of hold time. With NB_SYNC=2, the register loads at the 3rd rising edge at which the enable is sampled high.
- Loads: A, B and OP registers capture i_data on their pulse and set loaded flag a_v/b_v/op_v. Simultaneous pulses load all selected registers from the same i_data in that cycle.
- FSM states:
  - IDLE -> EXEC when a_v&b_v&op_v and a load pulse occurred this cycle. Any reload with all flags set re-triggers.
  - EXEC (1 cycle): result and flags register; o_valid=1 in the following cycle -> IDLE.
  - Load pulses arriving during EXEC are captured and re-trigger EXEC on return to IDLE.
- Latency: o_valid rises 2 edges after the final-operand load edge. o_data and flags hold until the next EXEC.
- Opcodes (NB_OP=6):
  - ADD 100000, SUB 100010: arithmetic; carry, zero and overflow valid.
  - AND 100100, OR 100101, XOR 100110, NOR 100111: logic; carry=0, overflow=0.
  - SRA 000011, SRL 000010: shift A by B[log2(NB_DATA)-1:0]; carry=0, overflow=0.
  - Any other opcode: result 0, o_err=1, zero=1, carry=0, overflow=0.
- ADD carry = bit NB_DATA of A+B. SUB computed as A+~B+1; carry=1 means no borrow (A>=B unsigned).
- Overflow (two's complement): ADD: sign(A)==sign(B) && sign(R)!=sign(A). SUB: sign(A)!=sign(B) && sign(R)!=sign(A).
- o_err clears on the next valid-opcode EXEC.
- Reset mid-EXEC: the result is discarded and o_valid is not asserted.

Optional Feature:
ALU_ACCUM_EN
- Defined: on every EXEC, the result is also written into A (same edge); a_v stays set. Loading only B (or only OP) re-executes with the chained value, giving an accumulator. If a load of A coincides with the EXEC edge, the A load wins.
- Undefined: A changes only via i_enable_1.

Decomposition:
- Package alu_pkg: opcode localparams, FSM state encoding (IDLE, EXEC), NB_FLAGS=4, flag bit indices.
- Sub-module alu_btn_sync: NB_SYNC synchroniser plus rising-edge pulse, one instance per enable.
- The combinational ALU function stays inside alu_seq_top.

Test Plan:
- A=0x7F, B=0x01, OP=ADD -> o_data=0x80, carry=0, zero=0, overflow=1, o_valid one cycle.
- A=0x05, B=0x05, OP=SUB -> 0x00, zero=1, carry=1, overflow=0; then B=0x06 reload only -> 0xFF, carry=0, new o_valid.
- A=0x80, B=0x03: SRA -> 0xF0; then OP=SRL reload -> 0x10. Then OP=0x3F -> 0x00, o_err=1; then OP=AND -> o_err=0.
- i_enable_2 held high 20 cycles, plus glitch pulses shorter than 1 clock -> exactly one B load, at most one o_valid per press.
- Reset asserted during EXEC -> all outputs 0 immediately, no o_valid. After release, a load of B alone produces no EXEC (flags cleared).
- ALU_ACCUM_EN: A=0x01, B=0x01, ADD, then 3 further B presses -> o_data 0x02, 0x03, 0x04, 0x05. Without the macro, the same stimulus gives 0x02 four times.
